// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write arbiter for a register file. It stages the
// winning write for one cycle and forwards the staged value to the read ports.
module regfile_write_arbiter #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             aValid,
  input  logic [4:0]       aRd,
  input  logic [Width-1:0] aData,
  output logic             aReady,

  input  logic             bValid,
  input  logic [4:0]       bRd,
  input  logic [Width-1:0] bData,
  output logic             bReady,

  output logic             regWrite,
  output logic [4:0]       rd,
  output logic [Width-1:0] writeData,

  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             fwd1Valid,
  output logic             fwd2Valid,
  output logic [Width-1:0] fwd1Data,
  output logic [Width-1:0] fwd2Data,

  output logic [15:0]      conflictCount
);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  grant_t           last_grant;
  logic             grant_a;
  logic             grant_b;
  logic             conflict;
  logic             xfer;
  logic [4:0]       xfer_rd;
  logic [Width-1:0] xfer_data;

  assign conflict = aValid && bValid;

  // NOTE: every output of this block gets a default on entry, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n) begin
      if (conflict) begin
        // Round-robin: the requester that did not win last time goes first.
        grant_a = (last_grant == GRANT_B);
        grant_b = (last_grant == GRANT_A);
      end else begin
        grant_a = aValid;
        grant_b = bValid;
      end
    end
  end

  assign aReady    = grant_a;
  assign bReady    = grant_b;
  assign xfer      = grant_a || grant_b;
  assign xfer_rd   = grant_b ? bRd   : aRd;
  assign xfer_data = grant_b ? bData : aData;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_B;
    end else if (grant_a) begin
      last_grant <= GRANT_A;
    end else if (grant_b) begin
      last_grant <= GRANT_B;
    end
  end

  // Writes to x0 are accepted but never enabled; rd/writeData still load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWrite  <= 1'b0;
      rd        <= 5'd0;
      writeData <= '0;
    end else begin
      regWrite <= xfer && (xfer_rd != 5'd0);
      if (xfer) begin
        rd        <= xfer_rd;
        writeData <= xfer_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflictCount <= 16'd0;
    end else if (conflict && (conflictCount != 16'hFFFF)) begin
      conflictCount <= conflictCount + 16'd1;
    end
  end

  assign fwd1Valid = regWrite && (rd == rs1) && (rs1 != 5'd0);
  assign fwd2Valid = regWrite && (rd == rs2) && (rs2 != 5'd0);
  assign fwd1Data  = writeData;
  assign fwd2Data  = writeData;

  a_one_hot_ready : assert property (@(posedge clk) !(aReady && bReady));

  // A requester that waits one cycle is guaranteed the next one.
  a_fair_a : assert property (@(posedge clk) disable iff (!rst_n)
    (aValid && !aReady) |=> (!aValid || aReady));
  a_fair_b : assert property (@(posedge clk) disable iff (!rst_n)
    (bValid && !bReady) |=> (!bValid || bReady));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table with a staged-write scoreboard,
// then reset-discard, post-reset grant and counter saturation sequences.
module tb_regfile_write_arbiter;

  localparam int Width = 32;
  localparam int NV    = 13;

  logic             clk;
  logic             rst_n;
  logic             aValid, bValid, aReady, bReady;
  logic [4:0]       aRd, bRd, rs1, rs2, rd;
  logic [Width-1:0] aData, bData, writeData, fwd1Data, fwd2Data;
  logic             regWrite, fwd1Valid, fwd2Valid;
  logic [15:0]      conflictCount;

  regfile_write_arbiter #(.Width(Width)) dut (
    .clk(clk), .rst_n(rst_n),
    .aValid(aValid), .aRd(aRd), .aData(aData), .aReady(aReady),
    .bValid(bValid), .bRd(bRd), .bData(bData), .bReady(bReady),
    .regWrite(regWrite), .rd(rd), .writeData(writeData),
    .rs1(rs1), .rs2(rs2),
    .fwd1Valid(fwd1Valid), .fwd2Valid(fwd2Valid),
    .fwd1Data(fwd1Data), .fwd2Data(fwd2Data),
    .conflictCount(conflictCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed by the staged write port; x0 deliberately not hardwired.
  logic [31:0] rf [32] = '{default: 32'd0};
  always @(posedge clk) if (regWrite) rf[rd] <= writeData;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        exp_ar;
    logic        exp_br;
    logic [15:0] exp_cc;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
  } stage_t;

  vec_t   vecs [NV];
  stage_t sb [$];
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                              logic bv, logic [4:0] brd, logic [31:0] bd,
                              logic [4:0] r1, logic [4:0] r2,
                              logic ear, logic ebr, logic [15:0] cc);
    vec_t v;
    v.av = av;   v.ard = ard; v.adata = ad;
    v.bv = bv;   v.brd = brd; v.bdata = bd;
    v.r1 = r1;   v.r2 = r2;
    v.exp_ar = ear; v.exp_br = ebr; v.exp_cc = cc;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stage_t e;
    logic   exp_f1, exp_f2;

    vecs[0]  = mk(1'b1, 5'd1, 32'hA1,   1'b1, 5'd2, 32'hB1,        5'd0, 5'd0, 1'b1, 1'b0, 16'd1);
    vecs[1]  = mk(1'b1, 5'd1, 32'hA2,   1'b1, 5'd2, 32'hB2,        5'd1, 5'd2, 1'b0, 1'b1, 16'd2);
    vecs[2]  = mk(1'b1, 5'd3, 32'hA3,   1'b1, 5'd4, 32'hB3,        5'd0, 5'd0, 1'b1, 1'b0, 16'd3);
    vecs[3]  = mk(1'b1, 5'd3, 32'hA4,   1'b1, 5'd4, 32'hB4,        5'd0, 5'd0, 1'b0, 1'b1, 16'd4);
    vecs[4]  = mk(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,         5'd5, 5'd0, 1'b1, 1'b0, 16'd4);
    vecs[5]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,         5'd5, 5'd5, 1'b0, 1'b0, 16'd4);
    vecs[6]  = mk(1'b1, 5'd6, 32'hC0,   1'b1, 5'd8, 32'hC1,        5'd0, 5'd0, 1'b0, 1'b1, 16'd5);
    vecs[7]  = mk(1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 1'b1, 16'd5);
    vecs[8]  = mk(1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hA5A5_0001, 5'd7, 5'd0, 1'b0, 1'b1, 16'd5);
    vecs[9]  = mk(1'b1, 5'd9, 32'hAA,   1'b1, 5'd9, 32'hBB,        5'd0, 5'd0, 1'b1, 1'b0, 16'd6);
    vecs[10] = mk(1'b1, 5'd9, 32'hAA,   1'b1, 5'd9, 32'hBB,        5'd9, 5'd9, 1'b0, 1'b1, 16'd7);
    vecs[11] = mk(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1, 1'b0, 16'd7);
    vecs[12] = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b0, 1'b0, 16'd7);

    // Reset with both requesters asserting: nothing may be granted.
    rst_n = 1'b0;
    aValid = 1'b1; aRd = 5'd1; aData = 32'h11;
    bValid = 1'b1; bRd = 5'd2; bData = 32'h22;
    rs1 = 5'd0; rs2 = 5'd0;
    #3;
    check("reset_a_ready",  32'(aReady), 32'd0);
    check("reset_b_ready",  32'(bReady), 32'd0);
    check("reset_regwrite", 32'(regWrite), 32'd0);
    check("reset_rd",       32'(rd), 32'd0);
    check("reset_wdata",    writeData, 32'd0);
    check("reset_cc",       32'(conflictCount), 32'd0);
    @(negedge clk);
    aValid = 1'b0; bValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      aValid = vecs[i].av; aRd = vecs[i].ard; aData = vecs[i].adata;
      bValid = vecs[i].bv; bRd = vecs[i].brd; bData = vecs[i].bdata;
      rs1 = vecs[i].r1; rs2 = vecs[i].r2;
      #1;
      check($sformatf("a_ready[%0d]", i), 32'(aReady), 32'(vecs[i].exp_ar));
      check($sformatf("b_ready[%0d]", i), 32'(bReady), 32'(vecs[i].exp_br));
      if (vecs[i].exp_ar) begin
        e.rw = (vecs[i].ard != 5'd0); e.rd = vecs[i].ard; e.data = vecs[i].adata;
      end else if (vecs[i].exp_br) begin
        e.rw = (vecs[i].brd != 5'd0); e.rd = vecs[i].brd; e.data = vecs[i].bdata;
      end else begin
        e.rw = 1'b0; e.rd = 5'd0; e.data = 32'd0;
      end
      sb.push_back(e);

      @(posedge clk);
      #1;
      e = sb.pop_front();
      exp_f1 = e.rw && (e.rd == vecs[i].r1) && (vecs[i].r1 != 5'd0);
      exp_f2 = e.rw && (e.rd == vecs[i].r2) && (vecs[i].r2 != 5'd0);
      check($sformatf("regwrite[%0d]", i), 32'(regWrite), 32'(e.rw));
      if (e.rw) begin
        check($sformatf("rd[%0d]", i),    32'(rd), 32'(e.rd));
        check($sformatf("wdata[%0d]", i), writeData, e.data);
        check($sformatf("fwd1_data[%0d]", i), fwd1Data, e.data);
        check($sformatf("fwd2_data[%0d]", i), fwd2Data, e.data);
      end
      check($sformatf("fwd1_valid[%0d]", i), 32'(fwd1Valid), 32'(exp_f1));
      check($sformatf("fwd2_valid[%0d]", i), 32'(fwd2Valid), 32'(exp_f2));
      check($sformatf("cc[%0d]", i), 32'(conflictCount), 32'(vecs[i].exp_cc));
    end

    check("rf_x0", rf[0], 32'd0);
    check("rf_5",  rf[5], 32'h1234);
    check("rf_6",  rf[6], 32'd0);
    check("rf_7",  rf[7], 32'hA5A5_0001);
    check("rf_8",  rf[8], 32'hC1);
    check("rf_9_order", rf[9], 32'hBB);

    // Stage a write to x3, then reset before it can commit.
    @(negedge clk);
    aValid = 1'b1; aRd = 5'd3; aData = 32'h3333_3333;
    bValid = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
    @(posedge clk);
    #1;
    check("mid_regwrite", 32'(regWrite), 32'd1);
    check("mid_rd",       32'(rd), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_drop_regwrite", 32'(regWrite), 32'd0);
    check("rst_drop_a_ready",  32'(aReady), 32'd0);
    check("rst_drop_wdata",    writeData, 32'd0);
    check("rst_drop_cc",       32'(conflictCount), 32'd0);
    @(posedge clk);
    #1;
    check("rf_3_no_commit", rf[3], 32'hA3);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_grant_ready", 32'(aReady), 32'd1);
    @(posedge clk);
    #1;
    check("first_grant_regwrite", 32'(regWrite), 32'd1);
    check("first_grant_wdata",    writeData, 32'h3333_3333);

    // Continuous conflict until the counter saturates.
    @(negedge clk);
    aValid = 1'b1; bValid = 1'b1; aRd = 5'd10; bRd = 5'd11;
    for (int n = 1; n <= 65540; n++) begin
      @(posedge clk);
      #1;
      if (n == 1)     check("cc_first",  32'(conflictCount), 32'd1);
      if (n == 65534) check("cc_fffe",   32'(conflictCount), 32'hFFFE);
      if (n == 65535) check("cc_ffff",   32'(conflictCount), 32'hFFFF);
      if (n == 65540) check("cc_sat",    32'(conflictCount), 32'hFFFF);
    end
    @(posedge clk);
    #1;
    check("cc_hold", 32'(conflictCount), 32'hFFFF);
    @(negedge clk);
    aValid = 1'b0; bValid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
